// File: rtl/nv_nvdla_sdp_rdma_req_arb_pkg.sv
// Shared definitions for the SDP RDMA read-request arbiter: pd field layout,
// channel id encodings and default credit sizing.
package nv_nvdla_sdp_rdma_req_arb_pkg;

    localparam int ARB_AW_DEF         = 64;
    localparam int ARB_SW_DEF         = 15;
    localparam int ARB_CREDIT_MAX_DEF = 256;
    localparam int ARB_CW_DEF         = 9;

    // DMA request pd is {size, addr}: addr in the low bits, size directly above it
    localparam int PD_ADDR_LSB = 0;

    typedef enum logic [1:0] {
        CH_MRDMA = 2'd0,
        CH_BRDMA = 2'd1,
        CH_NRDMA = 2'd2,
        CH_ERDMA = 2'd3
    } chan_id_e;

    function automatic int pd_size_lsb(input int aw);
        return PD_ADDR_LSB + aw;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_rdma_credit_cnt.sv
// Per-channel response-buffer credit counter: subtract on grant, add on return,
// saturate at CREDIT_MAX with a sticky overflow flag.
module nv_nvdla_sdp_rdma_credit_cnt
    import nv_nvdla_sdp_rdma_req_arb_pkg::*;
#(
    parameter int CREDIT_MAX = ARB_CREDIT_MAX_DEF,
    parameter int CW         = ARB_CW_DEF,
    parameter int NW         = ARB_SW_DEF + 1
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          take_i,
    input  logic [NW-1:0] need_i,
    input  logic          ret_i,
    output logic [CW-1:0] credit_o,
    output logic          full_o,
    output logic          err_o
);

    localparam int            XW   = max_int(CW, NW) + 1;
    localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

    logic [XW-1:0] sum;
    logic [CW-1:0] credit_q, credit_d;
    logic          err_q, err_d;

    // A grant only happens when credit covers need, so the sum never underflows
    always_comb begin
        sum      = XW'(credit_q) - (take_i ? XW'(need_i) : '0) + XW'(ret_i);
        credit_d = CW'(sum);
        err_d    = err_q;
        if (sum > XW'(CREDIT_MAX)) begin
            credit_d = CMAX;
            err_d    = 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            credit_q <= CMAX;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign credit_o = credit_q;
    assign full_o   = (credit_q == CMAX);
    assign err_o    = err_q;

endmodule

// File: rtl/nv_nvdla_sdp_rdma_req_arb.sv
// Credit-gated arbiter sharing the SDP DMA read-request port among RDMA requesters.
// Define NVDLA_SDP_RDMA_ARB_STRICT_PRIO_EN for fixed priority instead of round-robin.
module nv_nvdla_sdp_rdma_req_arb
    import nv_nvdla_sdp_rdma_req_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int AW         = ARB_AW_DEF,
    parameter int SW         = ARB_SW_DEF,
    parameter int CREDIT_MAX = ARB_CREDIT_MAX_DEF,
    parameter int CW         = ARB_CW_DEF
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic [NUM_REQ-1:0]    req_pvld,
    output logic [NUM_REQ-1:0]    req_prdy,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*SW-1:0] req_size,
    output logic                  dma_rd_req_pvld,
    input  logic                  dma_rd_req_prdy,
    output logic [AW+SW-1:0]      dma_rd_req_pd,
    output logic [1:0]            dma_rd_req_id,
    input  logic [NUM_REQ-1:0]    credit_ret,
    output logic                  arb_idle,
    output logic [NUM_REQ-1:0]    credit_err
);

    localparam int NW   = SW + 1;
    localparam int CMPW = max_int(CW, NW);

    logic [NUM_REQ-1:0][NW-1:0] need;
    logic [NUM_REQ-1:0][CW-1:0] credit;
    logic [NUM_REQ-1:0]         full;
    logic [NUM_REQ-1:0]         grant_vec;
    logic [3:0]                 elig;
    logic [3:0][AW+SW-1:0]      pd_in;
    logic                       slot_open;
    logic                       gnt_any;
    logic [1:0]                 gnt_idx;

    logic                       pvld_q;
    logic [AW+SW-1:0]           pd_q;
    chan_id_e                   id_q;

    assign slot_open = !pvld_q || dma_rd_req_prdy;

    // Unused channel slots are tied off so the search logic is always four wide
    for (genvar i = 0; i < 4; i++) begin : g_ch
        if (i < NUM_REQ) begin : g_on
            assign need[i]      = {1'b0, req_size[i*SW +: SW]} + NW'(1);
            assign elig[i]      = req_pvld[i] && (CMPW'(credit[i]) >= CMPW'(need[i]));
            assign pd_in[i]     = {req_size[i*SW +: SW], req_addr[i*AW +: AW]};
            assign grant_vec[i] = gnt_any && (gnt_idx == 2'(i));

            nv_nvdla_sdp_rdma_credit_cnt #(
                .CREDIT_MAX (CREDIT_MAX),
                .CW         (CW),
                .NW         (NW)
            ) u_cnt (
                .nvdla_core_clk  (nvdla_core_clk),
                .nvdla_core_rstn (nvdla_core_rstn),
                .take_i          (grant_vec[i]),
                .need_i          (need[i]),
                .ret_i           (credit_ret[i]),
                .credit_o        (credit[i]),
                .full_o          (full[i]),
                .err_o           (credit_err[i])
            );
        end else begin : g_off
            assign elig[i]  = 1'b0;
            assign pd_in[i] = '0;
        end
    end

`ifdef NVDLA_SDP_RDMA_ARB_STRICT_PRIO_EN
    // Descending scan so the lowest eligible index is the last one written
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (slot_open) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (elig[k]) begin
                    gnt_any = 1'b1;
                    gnt_idx = 2'(k);
                end
            end
        end
    end
`else
    localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

    logic [1:0] rr_q, rr_d;
    logic [2:0] rr_pos;

    // Scan offsets from rr downward so the closest eligible requester after rr wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_pos  = '0;
        if (slot_open) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                rr_pos = {1'b0, rr_q} + 3'(k);
                if (rr_pos >= 3'(NUM_REQ)) rr_pos = rr_pos - 3'(NUM_REQ);
                if (elig[rr_pos[1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = rr_pos[1:0];
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_any) rr_d = (gnt_idx == LAST_IDX) ? 2'd0 : gnt_idx + 2'd1;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) rr_q <= '0;
        else                  rr_q <= rr_d;
    end
`endif

    // Output stage reloads whenever a grant lands in an open slot, else drains on accept
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            pvld_q <= 1'b0;
            pd_q   <= '0;
            id_q   <= CH_MRDMA;
        end else if (gnt_any) begin
            pvld_q <= 1'b1;
            pd_q   <= pd_in[gnt_idx];
            id_q   <= chan_id_e'(gnt_idx);
        end else if (dma_rd_req_prdy) begin
            pvld_q <= 1'b0;
        end
    end

    assign req_prdy        = grant_vec;
    assign dma_rd_req_pvld = pvld_q;
    assign dma_rd_req_pd   = pd_q;
    assign dma_rd_req_id   = id_q;
    assign arb_idle        = !pvld_q && (&full);

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_req_arb.sv
// Scoreboard bench for the SDP RDMA request arbiter: directed vectors push expected
// DMA requests, an independent monitor pops them at each DMA handshake.
module tb_nv_nvdla_sdp_rdma_req_arb;

    localparam int NUM_REQ = 4;
    localparam int AW      = 64;
    localparam int SW      = 15;
    localparam int PDW     = AW + SW;

    typedef struct packed {
        logic [1:0]     id;
        logic [PDW-1:0] pd;
    } exp_t;

    logic                  nvdla_core_clk = 1'b0;
    logic                  nvdla_core_rstn = 1'b1;
    logic [NUM_REQ-1:0]    req_pvld = '0;
    logic [NUM_REQ-1:0]    req_prdy;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*SW-1:0] req_size;
    logic                  dma_rd_req_pvld;
    logic                  dma_rd_req_prdy = 1'b1;
    logic [PDW-1:0]        dma_rd_req_pd;
    logic [1:0]            dma_rd_req_id;
    logic [NUM_REQ-1:0]    credit_ret = '0;
    logic                  arb_idle;
    logic [NUM_REQ-1:0]    credit_err;

    logic [AW-1:0] tbAddr [NUM_REQ];
    logic [SW-1:0] tbSize [NUM_REQ];
    exp_t          sb [$];
    exp_t          monExp;
    int            perId [NUM_REQ];
    int            nCompared = 0;
    int            nMismatch = 0;

    nv_nvdla_sdp_rdma_req_arb dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .req_pvld        (req_pvld),
        .req_prdy        (req_prdy),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .dma_rd_req_pvld (dma_rd_req_pvld),
        .dma_rd_req_prdy (dma_rd_req_prdy),
        .dma_rd_req_pd   (dma_rd_req_pd),
        .dma_rd_req_id   (dma_rd_req_id),
        .credit_ret      (credit_ret),
        .arb_idle        (arb_idle),
        .credit_err      (credit_err)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
        assign req_addr[i*AW +: AW] = tbAddr[i];
        assign req_size[i*SW +: SW] = tbSize[i];
    end

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    function automatic void compare(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every DMA handshake must match the oldest expected request
    always @(negedge nvdla_core_clk) begin
        if (nvdla_core_rstn && dma_rd_req_pvld && dma_rd_req_prdy) begin
            if (sb.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("[TB] FAIL unexpected_dma_req: got id %0d pd %0h, required none", dma_rd_req_id, dma_rd_req_pd);
            end else begin
                monExp = sb.pop_front();
                compare("dma_id", 128'(dma_rd_req_id), 128'(monExp.id));
                compare("dma_pd", 128'(dma_rd_req_pd), 128'(monExp.pd));
                perId[dma_rd_req_id]++;
            end
        end
    end

    always @(negedge nvdla_core_clk) begin
        if (nvdla_core_rstn) begin
            assert ($onehot0(req_prdy)) else $error("[TB] req_prdy not one-hot: %b", req_prdy);
            for (int i = 0; i < NUM_REQ; i++) begin
                assert (!(req_pvld[i] && tbSize[i] > 15'd255))
                    else $error("[TB] illegal request size on requester %0d", i);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic stepCycle();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] pvld, input logic prdy, input logic [NUM_REQ-1:0] ret);
        req_pvld        = pvld;
        dma_rd_req_prdy = prdy;
        credit_ret      = ret;
    endtask

    // Checks the combinational grant and, when one is expected, queues the DMA request it must produce
    task automatic checkOutput(input int expG, input string name);
        exp_t e;
        logic [NUM_REQ-1:0] expPrdy;
        @(negedge nvdla_core_clk);
        expPrdy = (expG < 0) ? '0 : (NUM_REQ'(1) << expG);
        compare(name, 128'(req_prdy), 128'(expPrdy));
        if (expG >= 0) begin
            e.id = 2'(expG);
            e.pd = {tbSize[expG], tbAddr[expG]};
            sb.push_back(e);
        end
    endtask

    task automatic runCycle(input logic [NUM_REQ-1:0] pvld, input logic prdy, input logic [NUM_REQ-1:0] ret,
                            input int expG, input string name);
        applyStimulus(pvld, prdy, ret);
        checkOutput(expG, name);
        stepCycle();
    endtask

    task automatic doReset(input bit checkVals);
        applyStimulus('0, 1'b0, '0);
        nvdla_core_rstn = 1'b0;
        @(negedge nvdla_core_clk);
        sb.delete();
        if (checkVals) begin
            compare("rst_pvld", 128'(dma_rd_req_pvld), 128'(0));
            compare("rst_pd", 128'(dma_rd_req_pd), 128'(0));
            compare("rst_id", 128'(dma_rd_req_id), 128'(0));
            compare("rst_req_prdy", 128'(req_prdy), 128'(0));
            compare("rst_arb_idle", 128'(arb_idle), 128'(1));
            compare("rst_credit_err", 128'(credit_err), 128'(0));
            for (int i = 0; i < NUM_REQ; i++)
                compare("rst_credit", 128'(dut.credit[i]), 128'(256));
        end
        @(posedge nvdla_core_clk);
        #1;
        nvdla_core_rstn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            tbAddr[i] = 64'h0000_00A0_0000_1000 + 64'(i * 256);
            tbSize[i] = '0;
            perId[i]  = 0;
        end
        #1;
        doReset(1'b1);

        // Single request: size 3 takes 4 credits, four returns restore full
        tbSize[0] = 15'd3;
        tbAddr[0] = 64'h1000_0000_0000_0040;
        runCycle(4'b0001, 1'b1, 4'b0000, 0, "single_grant");
        applyStimulus(4'b0000, 1'b1, 4'b0000);
        checkOutput(-1, "single_idle_prdy");
        compare("single_credit0", 128'(dut.credit[0]), 128'(252));
        compare("single_arb_busy", 128'(arb_idle), 128'(0));
        stepCycle();
        for (int j = 0; j < 4; j++) runCycle(4'b0000, 1'b1, 4'b0001, -1, "single_ret");
        applyStimulus(4'b0000, 1'b1, 4'b0000);
        checkOutput(-1, "single_after_ret");
        compare("single_credit0_restored", 128'(dut.credit[0]), 128'(256));
        compare("single_arb_idle", 128'(arb_idle), 128'(1));
        stepCycle();

        // Fairness: all four valid with size 0, each grant's credit returned the next cycle
        doReset(1'b0);
        for (int i = 0; i < NUM_REQ; i++) begin
            tbSize[i] = '0;
            perId[i]  = 0;
        end
        for (int k = 0; k < 100; k++) begin
`ifdef NVDLA_SDP_RDMA_ARB_STRICT_PRIO_EN
            runCycle(4'b1111, 1'b1, (k == 0) ? 4'b0000 : 4'b0001, 0, "prio_grant");
`else
            runCycle(4'b1111, 1'b1, (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4)), k % 4, "rr_grant");
`endif
        end
`ifdef NVDLA_SDP_RDMA_ARB_STRICT_PRIO_EN
        runCycle(4'b0000, 1'b1, 4'b0001, -1, "prio_drain");
`else
        runCycle(4'b0000, 1'b1, 4'b1000, -1, "rr_drain");
`endif
        applyStimulus(4'b0000, 1'b1, 4'b0000);
        checkOutput(-1, "rr_idle_prdy");
        compare("rr_arb_idle", 128'(arb_idle), 128'(1));
`ifdef NVDLA_SDP_RDMA_ARB_STRICT_PRIO_EN
        compare("prio_count0", 128'(perId[0]), 128'(100));
        compare("prio_count3", 128'(perId[3]), 128'(0));
`else
        for (int i = 0; i < NUM_REQ; i++) compare("rr_count", 128'(perId[i]), 128'(25));
`endif
        stepCycle();

        // Credit block: a 256-atom request empties channel 1; the next waits for 256 returns
        doReset(1'b0);
        tbSize[1] = 15'd255;
        tbAddr[1] = 64'h2000_0000_0000_0100;
        runCycle(4'b0010, 1'b1, 4'b0000, 1, "blk_first_grant");
        applyStimulus(4'b0010, 1'b1, 4'b0010);
        checkOutput(-1, "blk_wait");
        compare("blk_credit_empty", 128'(dut.credit[1]), 128'(0));
        stepCycle();
        for (int j = 2; j <= 256; j++) runCycle(4'b0010, 1'b1, 4'b0010, -1, "blk_wait");
        applyStimulus(4'b0010, 1'b1, 4'b0000);
        checkOutput(1, "blk_second_grant");
        compare("blk_credit_full", 128'(dut.credit[1]), 128'(256));
        stepCycle();
        runCycle(4'b0000, 1'b1, 4'b0000, -1, "blk_drain");

        // Simultaneous grant and return, then overflow at CREDIT_MAX
        doReset(1'b0);
        tbSize[1] = 15'd251;
        runCycle(4'b0010, 1'b1, 4'b0000, 1, "sim_grant252");
        tbSize[1] = 15'd3;
        applyStimulus(4'b0010, 1'b1, 4'b0010);
        checkOutput(1, "sim_grant4");
        compare("sim_credit4", 128'(dut.credit[1]), 128'(4));
        stepCycle();
        applyStimulus(4'b0000, 1'b1, 4'b0000);
        checkOutput(-1, "sim_idle");
        compare("sim_credit1", 128'(dut.credit[1]), 128'(1));
        stepCycle();
        for (int j = 0; j < 255; j++) runCycle(4'b0000, 1'b1, 4'b0010, -1, "sim_ret");
        applyStimulus(4'b0000, 1'b1, 4'b0010);
        checkOutput(-1, "sim_extra_ret");
        compare("sim_credit_max", 128'(dut.credit[1]), 128'(256));
        compare("sim_err_clear", 128'(credit_err), 128'(0));
        stepCycle();
        applyStimulus(4'b0000, 1'b1, 4'b0000);
        checkOutput(-1, "sim_after_ovf");
        compare("sim_credit_sat", 128'(dut.credit[1]), 128'(256));
        compare("sim_err_set", 128'(credit_err), 128'(4'b0010));
        stepCycle();

        // Back-pressure: held request stays stable even when the requester's inputs change
        doReset(1'b0);
        tbSize[2] = 15'd7;
        tbAddr[2] = 64'h3000_0000_0000_0200;
        runCycle(4'b0100, 1'b0, 4'b0000, 2, "bp_first_grant");
        tbAddr[2] = 64'h3000_0000_0000_0A00;
        for (int j = 0; j < 10; j++) begin
            applyStimulus(4'b0100, 1'b0, 4'b0000);
            checkOutput(-1, "bp_hold_prdy");
            compare("bp_hold_pvld", 128'(dma_rd_req_pvld), 128'(1));
            compare("bp_hold_pd", 128'(dma_rd_req_pd), 128'({15'd7, 64'h3000_0000_0000_0200}));
            compare("bp_hold_id", 128'(dma_rd_req_id), 128'(2));
            stepCycle();
        end
        runCycle(4'b0100, 1'b1, 4'b0000, 2, "bp_release_grant");
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        checkOutput(-1, "bp_second_held");
        compare("bp_second_pvld", 128'(dma_rd_req_pvld), 128'(1));
        compare("bp_second_pd", 128'(dma_rd_req_pd), 128'({15'd7, 64'h3000_0000_0000_0A00}));
        stepCycle();

        // Reset while a request is held drops it and refills credits
        doReset(1'b1);
        runCycle(4'b0000, 1'b1, 4'b0000, -1, "post_rst_idle");
        compare("sb_drained", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
